// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-back path.
package rf_pkg;

   // Default geometry of the integer register file and its write-back sources.
   localparam int RF_N     = 5;
   localparam int RF_WIDTH = 32;
   localparam int RF_NREQ  = 2;

   // One write-back request. The destination field is called dst because
   // "reg" is a reserved word.
   typedef struct packed {
      logic [RF_N-1:0]     dst;
      logic [RF_WIDTH-1:0] data;
   } wb_req_t;

   // Reset values of the registered write port.
   localparam logic                RF_WEN_RST = 1'b0;
   localparam logic [RF_N-1:0]     RF_REG_RST = '0;
   localparam logic [RF_WIDTH-1:0] RF_DIN_RST = '0;

endpackage

// File: rtl/register_file.sv
// Integer register file with one write port and one combinational read port. r0 reads as zero.
module register_file
   import rf_pkg::*;
#(
   parameter int N     = RF_N,
   parameter int WIDTH = RF_WIDTH
) (
   input  logic             clk,
   input  logic             wenable,
   input  logic [N-1:0]     reg_in,
   input  logic [WIDTH-1:0] din,
   input  logic [N-1:0]     rd_reg,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [0:2**N-1];

   // Write port. The storage array has no reset.
   always_ff @(posedge clk) begin
      // NOTE: storage arrays are not reset; software must write a register before it reads it.
      if (wenable && reg_in != '0)
         mem[reg_in] <= din;
   end

   assign dout = (rd_reg == '0) ? '0 : mem[rd_reg];

endmodule

// File: rtl/rr_arbiter.sv
// One-hot grant among NREQ requesters.
// RF_WB_RR_EN defined: round-robin, with the search starting after the last winner.
// RF_WB_RR_EN undefined: fixed priority, where the lowest index wins and there is no pointer.
module rr_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = RF_NREQ
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] grant
);

`ifdef RF_WB_RR_EN
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] grant_idx;

   // Search from (ptr+1) mod NREQ and grant the first active requester.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
      grant     = '0;
      grant_idx = ptr;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(ptr) + k) % NREQ;
         if (grant == '0 && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
         end
      end
   end

   // The pointer follows the winner only when a transfer actually happens.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst)
         ptr <= PW'(NREQ - 1);
      else if (advance)
         ptr <= grant_idx;
   end
`else
   // Fixed priority: isolate the lowest set request bit.
   assign grant = req & (~req + NREQ'(1));

   logic unused_ctl;
   assign unused_ctl = ^{clk, rst, advance};
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-port controller for the register file. It arbitrates NREQ write-back requesters
// onto the single write port and keeps a pending-write scoreboard for the issue stage.
// RF_WB_RR_EN selects round-robin arbitration. The default build uses fixed priority.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int N     = RF_N,
   parameter int WIDTH = RF_WIDTH,
   parameter int NREQ  = RF_NREQ
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       wb_valid,
   input  logic [NREQ*N-1:0]     wb_reg,
   input  logic [NREQ*WIDTH-1:0] wb_data,
   output logic [NREQ-1:0]       wb_ready,
   input  logic                  alloc_valid,
   input  logic [N-1:0]          alloc_reg,
   output logic                  alloc_ok,
   input  logic [N-1:0]          chk_a,
   input  logic [N-1:0]          chk_b,
   output logic                  busy_a,
   output logic                  busy_b,
   output logic                  rf_wenable,
   output logic [N-1:0]          rf_reg_in,
   output logic [WIDTH-1:0]      rf_din
);

   logic [NREQ-1:0]  grant;
   logic             xfer;
   logic [N-1:0]     win_reg;
   logic [WIDTH-1:0] win_data;
   logic [2**N-1:1]  pending;
   logic [2**N-1:0]  pend_full;
   logic [2**N-1:1]  pend_next;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (wb_valid),
      .advance (xfer),
      .grant   (grant)
   );

   // Grants are suppressed while reset is held.
   assign wb_ready = grant & {NREQ{rst}};
   assign xfer     = |wb_ready;

   // Select the destination and data of the granted requester.
   always_comb begin
      win_reg  = '0;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (wb_ready[i]) begin
            win_reg  = wb_reg[i*N +: N];
            win_data = wb_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // r0 is appended as a never-pending bit so that lookups need no special case.
   assign pend_full = {pending, 1'b0};
   assign alloc_ok  = rst & alloc_valid & ~pend_full[alloc_reg];
   assign busy_a    = pend_full[chk_a];
   assign busy_b    = pend_full[chk_b];

   // Set on accepted allocation, then clear on write-back. The clear wins on a collision.
   always_comb begin
      pend_next = pending;
      if (alloc_ok && alloc_reg != '0)
         pend_next[alloc_reg] = 1'b1;
      if (xfer && win_reg != '0)
         pend_next[win_reg] = 1'b0;
   end

   // Scoreboard state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pending <= '0;
      else
         pending <= pend_next;
   end

   // Registered write port. Writes to r0 are issued with the enable low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_wenable <= RF_WEN_RST;
         rf_reg_in  <= N'(RF_REG_RST);
         rf_din     <= WIDTH'(RF_DIN_RST);
      end else begin
         rf_wenable <= xfer && (win_reg != '0);
         if (xfer) begin
            rf_reg_in <= win_reg;
            rf_din    <= win_data;
         end
      end
   end

endmodule
